// File: rtl/rr_mux_8to1_pkg.sv
// Shared constants and types for the 8-lane round-robin multiplexer.
// Lane count and select width live here so the top and arbiter agree on sizing.

package rr_mux_8to1_pkg;

   localparam int unsigned NUM_LANES = 8;
   localparam int unsigned SEL_W     = 3;

   // Output stage occupancy: EMPTY means out_valid is low, FULL means a word is held.
   typedef enum logic [0:0] {
      StEmpty = 1'b0,
      StFull  = 1'b1
   } state_e;

   // Lane after idx, wrapping naturally within SEL_W bits (7 -> 0).
   function automatic logic [SEL_W-1:0] next_lane(input logic [SEL_W-1:0] idx);
      return idx + SEL_W'(1);
   endfunction

endpackage

// File: rtl/rr_arbiter_8.sv
// Purely combinational round-robin arbiter: grants the first requesting lane
// found when searching from ptr upward, wrapping modulo NUM_LANES.

module rr_arbiter_8
   import rr_mux_8to1_pkg::*;
(
   input  logic [NUM_LANES-1:0] req,
   input  logic [SEL_W-1:0]     ptr,
   output logic [NUM_LANES-1:0] gnt_onehot,
   output logic [SEL_W-1:0]     gnt_idx,
   output logic                 any_gnt
);

   logic [SEL_W-1:0] idx;

   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      any_gnt    = 1'b0;
      idx        = '0;
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
         // Offset addition wraps in SEL_W bits, giving the modulo search order.
         idx = ptr + SEL_W'(k);
         if (!any_gnt && req[idx]) begin
            any_gnt = 1'b1;
            gnt_idx = idx;
         end
      end
      gnt_onehot[gnt_idx] = any_gnt;
   end

endmodule

// File: rtl/rr_mux_8to1.sv
// Eight-lane valid/ready round-robin multiplexer with a single registered output stage.
// The output register reloads in the same cycle it is drained, so throughput is one word/cycle.

module rr_mux_8to1
   import rr_mux_8to1_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_LANES*WIDTH-1:0] in_data,
   input  logic [NUM_LANES-1:0]       in_valid,
   output logic [NUM_LANES-1:0]       in_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [SEL_W-1:0]           out_sel,
   output logic                       out_valid,
   input  logic                       out_ready
);

   state_e              state_q, state_d;
   logic [SEL_W-1:0]    ptr_q;
   logic [WIDTH-1:0]    data_q;
   logic [SEL_W-1:0]    sel_q;

   logic                loadable;
   logic [NUM_LANES-1:0] arb_req;
   logic [NUM_LANES-1:0] gnt_onehot;
   logic [SEL_W-1:0]    gnt_idx;
   logic                any_gnt;
   logic [WIDTH-1:0]    lane_data [NUM_LANES];
   logic [WIDTH-1:0]    grant_data;

   always_comb begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         lane_data[i] = in_data[i*WIDTH +: WIDTH];
      end
   end

   assign loadable = (state_q == StEmpty) || out_ready;
   // Masking requests (not grants) keeps in_ready zero during reset and stalls.
   assign arb_req  = (loadable && !rst) ? in_valid : '0;

   rr_arbiter_8 u_arbiter (
      .req        (arb_req),
      .ptr        (ptr_q),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .any_gnt    (any_gnt)
   );

   assign grant_data = lane_data[gnt_idx];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StEmpty: begin
            if (any_gnt) begin
               state_d = StFull;
            end
         end
         StFull: begin
            if (out_ready && !any_gnt) begin
               state_d = StEmpty;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StEmpty;
         ptr_q   <= '0;
         data_q  <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         if (any_gnt) begin
            data_q <= grant_data;
            sel_q  <= gnt_idx;
            ptr_q  <= next_lane(gnt_idx);
         end
      end
   end

   assign in_ready  = gnt_onehot;
   assign out_valid = (state_q == StFull);
   assign out_data  = data_q;
   assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_mux_8to1.sv
// Directed bench for rr_mux_8to1: a queue-free reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.

module tb_rr_mux_8to1;

   localparam int W = 8;

   logic          clk;
   logic          rst;
   logic [8*W-1:0] in_data;
   logic [7:0]    in_valid;
   logic [7:0]    in_ready;
   logic [W-1:0]  out_data;
   logic [2:0]    out_sel;
   logic          out_valid;
   logic          out_ready;

   int total;
   int bad;
   bit model_en;

   // Reference model state.
   int  m_ptr;
   bit  m_valid;
   int  m_data;
   int  m_sel;

   rr_mux_8to1 #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Lane that must be granted this cycle, or -1 when none.
   function automatic int exp_grant();
      if (rst) return -1;
      if (m_valid && !out_ready) return -1;
      for (int k = 0; k < 8; k++) begin
         int l;
         l = (m_ptr + k) % 8;
         if (in_valid[l]) return l;
      end
      return -1;
   endfunction

   function automatic int lane_word(input int l);
      return int'(in_data[l*W +: W]);
   endfunction

   always @(posedge clk) begin
      int g;
      if (rst) begin
         m_ptr = 0; m_valid = 0; m_data = 0; m_sel = 0;
      end else begin
         g = exp_grant();
         if (g >= 0) begin
            m_valid = 1; m_data = lane_word(g); m_sel = g; m_ptr = (g + 1) % 8;
         end else if (out_ready) begin
            m_valid = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (model_en) begin
         int g;
         g = exp_grant();
         chk("model in_ready", int'(in_ready), (g < 0) ? 0 : (1 << g));
         chk("model out_valid", int'(out_valid), int'(m_valid));
         chk("model out_data", int'(out_data), m_data);
         chk("model out_sel", int'(out_sel), m_sel);
      end
   end

   // Apply inputs just after a rising edge, return just after the following falling edge.
   task automatic drive(input logic r, input logic [7:0] v, input logic ordy);
      @(posedge clk);
      #1;
      rst = r; in_valid = v; out_ready = ordy;
      @(negedge clk);
      #1;
   endtask

   initial begin
      total = 0; bad = 0; model_en = 0;
      m_ptr = 0; m_valid = 0; m_data = 0; m_sel = 0;
      rst = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) in_data[i*W +: W] = W'(8'h30 + i);
      in_data[3*W +: W] = 8'hA5;

      drive(1'b1, 8'hFF, 1'b1);
      chk("reset in_ready zero", int'(in_ready), 0);
      model_en = 1;
      drive(1'b1, 8'h00, 1'b1);
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset out_data", int'(out_data), 0);
      chk("reset out_sel", int'(out_sel), 0);

      // Single lane 3.
      drive(1'b0, 8'h08, 1'b1);
      chk("single in_ready", int'(in_ready), 8'h08);
      drive(1'b0, 8'h00, 1'b1);
      chk("single out_valid", int'(out_valid), 1);
      chk("single out_data", int'(out_data), 8'hA5);
      chk("single out_sel", int'(out_sel), 3);
      // Drain then idle: pointer must stay at 4.
      drive(1'b0, 8'h00, 1'b1);
      chk("drain out_valid", int'(out_valid), 0);
      drive(1'b0, 8'h00, 1'b1);
      drive(1'b0, 8'hFF, 1'b1);
      chk("idle ptr kept", int'(in_ready), 8'h10);

      // Fairness from a fresh reset, lane i data = i.
      for (int i = 0; i < 8; i++) in_data[i*W +: W] = W'(i);
      drive(1'b1, 8'hFF, 1'b1);
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, 8'hFF, 1'b1);
         chk("fair in_ready", int'(in_ready), 1 << k);
         if (k > 0) begin
            chk("fair out_sel", int'(out_sel), k - 1);
            chk("fair out_valid", int'(out_valid), 1);
         end
      end
      // Wrap: ptr is 0 after lane 7, so lane 0 wins over lane 7.
      drive(1'b0, 8'h81, 1'b1);
      chk("wrap in_ready", int'(in_ready), 8'h01);
      chk("wrap out_sel", int'(out_sel), 7);
      drive(1'b0, 8'h80, 1'b1);
      chk("wrap next in_ready", int'(in_ready), 8'h80);
      chk("wrap seq out_sel", int'(out_sel), 0);

      // Backpressure with lane 2 held.
      drive(1'b0, 8'h04, 1'b1);
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 8'hFF, 1'b0);
         chk("bp in_ready", int'(in_ready), 0);
         chk("bp out_valid", int'(out_valid), 1);
         chk("bp out_sel", int'(out_sel), 2);
         chk("bp out_data", int'(out_data), 2);
      end
      drive(1'b0, 8'hFF, 1'b1);
      chk("bp release in_ready", int'(in_ready), 8'h08);
      drive(1'b0, 8'h00, 1'b1);
      chk("bp release out_sel", int'(out_sel), 3);

      // Lane withdraws during a stall: no grant, no data.
      drive(1'b0, 8'h02, 1'b1);
      drive(1'b0, 8'h20, 1'b0);
      chk("withdraw stall in_ready", int'(in_ready), 0);
      drive(1'b0, 8'h00, 1'b1);
      chk("withdraw in_ready", int'(in_ready), 0);
      chk("withdraw out_sel", int'(out_sel), 1);

      // Reset mid-stream with lane 5 held.
      drive(1'b0, 8'h20, 1'b1);
      drive(1'b1, 8'hFF, 1'b1);
      chk("mid rst out_sel before", int'(out_sel), 5);
      chk("mid rst in_ready", int'(in_ready), 0);
      drive(1'b0, 8'hFF, 1'b1);
      chk("mid rst out_valid", int'(out_valid), 0);
      chk("mid rst out_sel", int'(out_sel), 0);
      chk("mid rst out_data", int'(out_data), 0);
      chk("mid rst first grant", int'(in_ready), 8'h01);
      drive(1'b0, 8'h00, 1'b1);
      chk("mid rst first out_sel", int'(out_sel), 0);
      chk("mid rst first out_valid", int'(out_valid), 1);
      drive(1'b0, 8'h00, 1'b1);

      model_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
